seg7_msg_player: RTL and testbench
==================================

Name: seg7_msg_player

Overview:
Parametrised seven-segment message sequencer for the TinyTapeout user slot. It holds a writable buffer of raw 8-bit segment patterns and plays them out one character at a time. Each character shows for a programmable dwell period, followed by an optional blank gap. Supports one-shot and loop modes, pause and stop, and common-cathode or common-anode output polarity.

Parameters:
PRESCALE_W, 22, width of the dwell prescaler and of the dwell input
MAX_LEN, 16, message buffer depth in characters (power of two, 2..32)
END_BLANK, 2, blank ticks inserted after the last character in loop mode (0 allowed)
COMMON_ANODE, 0, 1 inverts all eight seg_out bits

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
wr_en  in  1  write wr_data into buffer[wr_addr] on this edge
wr_addr  in  $clog2(MAX_LEN)  buffer write address
wr_data  in  8  segment pattern, bit order xGFEDCBA (bit7 = dp), logical 1 = segment lit
len  in  $clog2(MAX_LEN)+1  message length, sampled on start
dwell  in  PRESCALE_W  clock cycles per tick; 0 is treated as 1; sampled on start
gap_en  in  1  insert one blank tick after every character; sampled on start
loop  in  1  1 = repeat message, 0 = play once; sampled on start
start  in  1  begin playback from character 0
stop  in  1  abort playback
pause  in  1  freeze playback while high
seg_out  out  8  segment drive, after polarity
busy  out  1  high while not IDLE
done  out  1  one-cycle end-of-message pulse
char_idx  out  $clog2(MAX_LEN)  index of the current or last character

Behaviour:
- Reset: buffer cleared to 0x00; FSM set to IDLE; prescaler, char_idx, busy and done set to 0; seg_out = blank.
- Blank is 0x00 when COMMON_ANODE=0 and 0xFF when COMMON_ANODE=1. All seg_out values are bitwise inverted when COMMON_ANODE=1.
- seg_out, busy and char_idx are combinational from registered state only. Buffer writes are visible from the next cycle, including during playback.
- Tick: the prescaler counts 0..D-1, where D = max(dwell_q,1). A tick occurs in the cycle the prescaler equals D-1; the prescaler then returns to 0. One unit therefore lasts exactly D cycles.
- Start latches len_q = min(len, MAX_LEN), dwell_q, gap_en_q and loop_q.
- FSM states:
  - IDLE: seg_out blank. On start with len≠0, go to SHOW with idx=0 and prescaler=0. Start with len=0 is ignored.
  - SHOW: seg_out = buffer[idx]; lasts one unit. Then go to GAP if gap_en_q, otherwise to NEXT handling.
  - GAP: seg_out blank; lasts one unit, then NEXT handling.
  - NEXT handling (no dedicated cycle):
    - If idx < len_q-1: idx+1 and go to SHOW.
    - Else if loop_q: go to ENDB, or go straight to SHOW with idx=0 if END_BLANK=0.
    - Else go to IDLE.
  - ENDB: seg_out blank; lasts END_BLANK units, then SHOW with idx=0.
- done: high for exactly the first cycle after the last character's final unit completes. This is the IDLE entry cycle in one-shot mode, and the ENDB or SHOW(0) entry cycle in loop mode.
- pause=1 while busy: prescaler, state and idx are held; seg_out is unchanged; no tick and no done occur. Playback resumes where it stopped.
- stop=1: next cycle is IDLE with prescaler=0; no done pulse. Stop takes priority over start and pause.
- start while busy: restarts at SHOW idx 0, prescaler 0, with inputs re-sampled. start takes priority over pause.
- A tick coinciding with start or stop is discarded.
- reset mid-playback: same result as the reset at power-up, including a cleared buffer.
- char_idx holds its last value in IDLE and is cleared only by reset.

Test Plan:
- Basic one-shot: buffer = {0x76, 0x79}, len=2, dwell=3, gap_en=1, loop=0, start in cycle 0 -> seg_out is 0x76 in cycles 1-3, 0x00 in 4-6, 0x79 in 7-9, 0x00 in 10-12; busy=1 for cycles 1-12; cycle 13 has busy=0 and done=1; done=0 from cycle 14.
- Loop with end blank: len=1, buffer[0]=0x3F, dwell=2, gap_en=1, loop=1, END_BLANK=2 -> SHOW in cycles 1-2, GAP 3-4, ENDB 5-8, SHOW 9-10; done=1 only in cycles 5 and 13.
- No-gap and dwell=0 corner: dwell=0, gap_en=0, len=3 -> each character shows for 1 cycle back to back (cycles 1, 2, 3); done in cycle 4; len=0 start leaves busy=0.
- Polarity: COMMON_ANODE=1, buffer[0]=0x76 -> IDLE seg_out = 0xFF, SHOW seg_out = 0x89.
- Pause/stop: dwell=4, pause high for cycles 2-6 -> character 0 is visible in cycles 1-9 (four active cycles plus five paused); stop in mid-GAP -> IDLE next cycle with seg_out blank and no done pulse.
- Clamp and restart: len=MAX_LEN+1 -> exactly MAX_LEN characters play. A start issued in the middle of character 5 -> char_idx=0 and the prescaler restarts in the next cycle.

Source files
------------

// File: rtl/seg7_msg_player_if.sv
// Host-side bus of the seven-segment message player: buffer write port,
// playback controls and the display/status outputs.
interface seg7_msg_player_if #(
  parameter int PRESCALE_W = 22,
  parameter int MAX_LEN    = 16
);
  localparam int AW = $clog2(MAX_LEN);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [7:0]            wr_data;
  logic [AW:0]           len;
  logic [PRESCALE_W-1:0] dwell;
  logic                  gap_en;
  logic                  loop;
  logic                  start;
  logic                  stop;
  logic                  pause;
  logic [7:0]            seg_out;
  logic                  busy;
  logic                  done;
  logic [AW-1:0]         char_idx;

  modport master (
    output wr_en, wr_addr, wr_data, len, dwell, gap_en, loop, start, stop, pause,
    input  seg_out, busy, done, char_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, dwell, gap_en, loop, start, stop, pause,
    output seg_out, busy, done, char_idx
  );
endinterface

// File: rtl/seg7_msg_player.sv
// Seven-segment message sequencer: plays a buffer of raw segment patterns one
// character per dwell unit, with optional blank gaps, looping, pause and stop.
module seg7_msg_player #(
  parameter int PRESCALE_W   = 22,
  parameter int MAX_LEN      = 16,
  parameter int END_BLANK    = 2,
  parameter int COMMON_ANODE = 0
) (
  input logic               clk,
  input logic               reset,
  seg7_msg_player_if.slave  bus
);
  localparam int AW  = $clog2(MAX_LEN);
  localparam int EBW = (END_BLANK > 1) ? $clog2(END_BLANK) : 1;
  localparam logic [EBW-1:0] EB_LAST = EBW'((END_BLANK > 0) ? END_BLANK - 1 : 0);
  localparam logic [AW:0]    LEN_MAX = (AW+1)'(MAX_LEN);
  localparam logic [7:0]     POLARITY = (COMMON_ANODE != 0) ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {IDLE, SHOW, GAP, ENDB} state_t;

  logic [7:0]            buffer [MAX_LEN];
  state_t                state;
  logic [PRESCALE_W-1:0] presc;
  logic [PRESCALE_W-1:0] dwell_q;
  logic [PRESCALE_W-1:0] presc_last;
  logic [AW-1:0]         idx;
  logic [AW:0]           len_q;
  logic                  gap_en_q;
  logic                  loop_q;
  logic                  done_q;
  logic [EBW-1:0]        eb_cnt;
  logic                  tick;
  logic                  last_char;
  state_t                adv_state;
  logic [AW-1:0]         adv_idx;
  logic                  adv_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) buffer[i] <= 8'h00;
    end else if (bus.wr_en) begin
      buffer[bus.wr_addr] <= bus.wr_data;
    end
  end

  // A dwell of 0 behaves like 1, so the last prescaler count never underflows.
  assign presc_last = (dwell_q == '0) ? '0 : dwell_q - 1'b1;
  assign tick       = (presc == presc_last);
  assign last_char  = ({1'b0, idx} == len_q - 1'b1);

  // Where playback goes once a character (and its gap, if any) has finished.
  always_comb begin
    adv_state = SHOW;
    adv_idx   = idx + 1'b1;
    adv_done  = 1'b0;
    if (last_char) begin
      adv_done = 1'b1;
      adv_idx  = idx;
      if (!loop_q) begin
        adv_state = IDLE;
      end else if (END_BLANK == 0) begin
        adv_idx = '0;
      end else begin
        adv_state = ENDB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      idx      <= '0;
      len_q    <= '0;
      dwell_q  <= '0;
      gap_en_q <= 1'b0;
      loop_q   <= 1'b0;
      done_q   <= 1'b0;
      eb_cnt   <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state <= IDLE;
        presc <= '0;
      end else if (bus.start && bus.len != '0) begin
        state    <= SHOW;
        idx      <= '0;
        presc    <= '0;
        eb_cnt   <= '0;
        len_q    <= (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
        dwell_q  <= bus.dwell;
        gap_en_q <= bus.gap_en;
        loop_q   <= bus.loop;
      end else if (state != IDLE && !bus.pause) begin
        if (!tick) begin
          presc <= presc + 1'b1;
        end else begin
          presc <= '0;
          case (state)
            SHOW: begin
              if (gap_en_q) begin
                state <= GAP;
              end else begin
                state  <= adv_state;
                idx    <= adv_idx;
                done_q <= adv_done;
              end
            end
            GAP: begin
              state  <= adv_state;
              idx    <= adv_idx;
              done_q <= adv_done;
            end
            ENDB: begin
              if (eb_cnt == EB_LAST) begin
                state  <= SHOW;
                idx    <= '0;
                eb_cnt <= '0;
              end else begin
                eb_cnt <= eb_cnt + 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.seg_out  = ((state == SHOW) ? buffer[idx] : 8'h00) ^ POLARITY;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.char_idx = idx;
endmodule

// File: tb/tb_seg7_msg_player.sv
// Bench for seg7_msg_player: two instances (common cathode with end blank,
// common anode without) against a unit-schedule reference model.
module tb_seg7_msg_player;
  localparam int PW   = 22;
  localparam int ML   = 16;
  localparam int AW   = 4;
  localparam int EB_A = 2;
  localparam int EB_B = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg7_msg_player_if #(.PRESCALE_W(PW), .MAX_LEN(ML)) bus_a ();
  seg7_msg_player_if #(.PRESCALE_W(PW), .MAX_LEN(ML)) bus_b ();

  assign bus_b.wr_en   = bus_a.wr_en;
  assign bus_b.wr_addr = bus_a.wr_addr;
  assign bus_b.wr_data = bus_a.wr_data;
  assign bus_b.len     = bus_a.len;
  assign bus_b.dwell   = bus_a.dwell;
  assign bus_b.gap_en  = bus_a.gap_en;
  assign bus_b.loop    = bus_a.loop;
  assign bus_b.start   = bus_a.start;
  assign bus_b.stop    = bus_a.stop;
  assign bus_b.pause   = bus_a.pause;

  seg7_msg_player #(.PRESCALE_W(PW), .MAX_LEN(ML), .END_BLANK(EB_A), .COMMON_ANODE(0))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  seg7_msg_player #(.PRESCALE_W(PW), .MAX_LEN(ML), .END_BLANK(EB_B), .COMMON_ANODE(1))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int check_count = 0;
  int pass_count  = 0;

  int s_reset, s_wr_en, s_wr_addr, s_wr_data, s_len, s_dwell;
  int s_gap, s_loop, s_start, s_stop, s_pause;

  // Reference model: a start expands the message into a flat list of display
  // units; playback walks that list, one unit per D active cycles.
  int mem [ML];
  int u_kind  [2][64];
  int u_idx   [2][64];
  int u_final [2][64];
  int u_n    [2];
  int m_busy [2];
  int m_pos  [2];
  int m_cyc  [2];
  int m_d    [2];
  int m_idx  [2];
  int m_loop [2];
  int m_done [2];

  function automatic int ebOf(input int m);
    return (m == 0) ? EB_A : EB_B;
  endfunction

  function automatic void buildSchedule(input int m, input int l, input int gap, input int lp);
    int n = 0;
    for (int i = 0; i < l; i++) begin
      u_kind[m][n] = 1; u_idx[m][n] = i; u_final[m][n] = (i == l - 1 && gap == 0) ? 1 : 0;
      n++;
      if (gap != 0) begin
        u_kind[m][n] = 0; u_idx[m][n] = i; u_final[m][n] = (i == l - 1) ? 1 : 0;
        n++;
      end
    end
    if (lp != 0) begin
      for (int k = 0; k < ebOf(m); k++) begin
        u_kind[m][n] = 0; u_idx[m][n] = l - 1; u_final[m][n] = 0;
        n++;
      end
    end
    u_n[m] = n;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < ML; i++) mem[i] = 0;
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 0; m_pos[m] = 0; m_cyc[m] = 0; m_d[m] = 1;
      m_idx[m] = 0; m_loop[m] = 0; m_done[m] = 0; u_n[m] = 0;
    end
  endfunction

  function automatic void modelStep();
    for (int m = 0; m < 2; m++) begin
      m_done[m] = 0;
      if (s_stop != 0) begin
        m_busy[m] = 0;
      end else if (s_start != 0 && s_len != 0) begin
        buildSchedule(m, (s_len > ML) ? ML : s_len, s_gap, s_loop);
        m_d[m] = (s_dwell == 0) ? 1 : s_dwell;
        m_loop[m] = s_loop;
        m_busy[m] = 1; m_pos[m] = 0; m_cyc[m] = 0; m_idx[m] = 0;
      end else if (m_busy[m] != 0 && s_pause == 0) begin
        m_cyc[m]++;
        if (m_cyc[m] == m_d[m]) begin
          m_cyc[m] = 0;
          if (u_final[m][m_pos[m]] != 0) m_done[m] = 1;
          m_pos[m]++;
          if (m_pos[m] == u_n[m]) begin
            if (m_loop[m] != 0) m_pos[m] = 0;
            else m_busy[m] = 0;
          end
          if (m_busy[m] != 0) m_idx[m] = u_idx[m][m_pos[m]];
        end
      end
    end
    if (s_wr_en != 0) mem[s_wr_addr] = s_wr_data;
  endfunction

  function automatic int expSeg(input int m);
    int e = 0;
    if (m_busy[m] != 0) begin
      if (u_kind[m][m_pos[m]] == 1) e = mem[m_idx[m]];
    end
    if (m == 1) e = e ^ 'hFF;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic compareAll();
    checkOutput("segA",  32'(bus_a.seg_out),  32'(expSeg(0)));
    checkOutput("busyA", 32'(bus_a.busy),     32'(m_busy[0]));
    checkOutput("doneA", 32'(bus_a.done),     32'(m_done[0]));
    checkOutput("idxA",  32'(bus_a.char_idx), 32'(m_idx[0]));
    checkOutput("segB",  32'(bus_b.seg_out),  32'(expSeg(1)));
    checkOutput("busyB", 32'(bus_b.busy),     32'(m_busy[1]));
    checkOutput("doneB", 32'(bus_b.done),     32'(m_done[1]));
    checkOutput("idxB",  32'(bus_b.char_idx), 32'(m_idx[1]));
  endtask

  // Drives one cycle of stimulus, advances the model, then checks mid-cycle.
  task automatic applyStimulus();
    reset         = (s_reset != 0);
    bus_a.wr_en   = (s_wr_en != 0);
    bus_a.wr_addr = AW'(s_wr_addr);
    bus_a.wr_data = 8'(s_wr_data);
    bus_a.len     = (AW+1)'(s_len);
    bus_a.dwell   = PW'(s_dwell);
    bus_a.gap_en  = (s_gap != 0);
    bus_a.loop    = (s_loop != 0);
    bus_a.start   = (s_start != 0);
    bus_a.stop    = (s_stop != 0);
    bus_a.pause   = (s_pause != 0);
    if (s_reset != 0) modelReset();
    else modelStep();
    @(negedge clk);
    compareAll();
    s_reset = 0; s_wr_en = 0; s_start = 0; s_stop = 0;
  endtask

  task automatic writeChar(input int addr, input int data);
    s_wr_en = 1; s_wr_addr = addr; s_wr_data = data;
    applyStimulus();
  endtask

  task automatic setupPlay(input int len, input int dwell, input int gap, input int lp);
    s_len = len; s_dwell = dwell; s_gap = gap; s_loop = lp; s_start = 1;
  endtask

  initial begin
    s_reset = 1; s_wr_en = 0; s_wr_addr = 0; s_wr_data = 0; s_len = 0; s_dwell = 0;
    s_gap = 0; s_loop = 0; s_start = 0; s_stop = 0; s_pause = 0;
    applyStimulus();
    s_reset = 1;
    applyStimulus();
    checkOutput("rst_segA", 32'(bus_a.seg_out), 32'h00);
    checkOutput("rst_segB", 32'(bus_b.seg_out), 32'hFF);

    $display("[TB] one-shot with gaps");
    writeChar(0, 'h76);
    writeChar(1, 'h79);
    setupPlay(2, 3, 1, 0);
    applyStimulus();
    checkOutput("one_seg1A", 32'(bus_a.seg_out), 32'h76);
    checkOutput("one_seg1B", 32'(bus_b.seg_out), 32'h89);
    for (int c = 2; c <= 14; c++) begin
      applyStimulus();
      if (c == 7)  checkOutput("one_seg7A", 32'(bus_a.seg_out), 32'h79);
      if (c == 12) checkOutput("one_busy12A", 32'(bus_a.busy), 32'd1);
      if (c == 13) checkOutput("one_done13A", 32'(bus_a.done), 32'd1);
      if (c == 13) checkOutput("one_busy13A", 32'(bus_a.busy), 32'd0);
      if (c == 14) checkOutput("one_done14A", 32'(bus_a.done), 32'd0);
    end

    $display("[TB] loop with end blank");
    writeChar(0, 'h3F);
    setupPlay(1, 2, 1, 1);
    applyStimulus();
    for (int c = 2; c <= 14; c++) begin
      applyStimulus();
      if (c == 5 || c == 13) checkOutput("loop_doneA", 32'(bus_a.done), 32'd1);
      if (c == 9)  checkOutput("loop_done9A", 32'(bus_a.done), 32'd0);
      if (c == 9)  checkOutput("loop_seg9A", 32'(bus_a.seg_out), 32'h3F);
    end
    s_stop = 1;
    applyStimulus();

    $display("[TB] dwell zero, no gap");
    setupPlay(3, 0, 0, 0);
    applyStimulus();
    for (int c = 2; c <= 5; c++) begin
      applyStimulus();
      if (c == 3) checkOutput("fast_idx3A", 32'(bus_a.char_idx), 32'd2);
      if (c == 4) checkOutput("fast_done4A", 32'(bus_a.done), 32'd1);
      if (c == 4) checkOutput("fast_busy4A", 32'(bus_a.busy), 32'd0);
    end
    setupPlay(0, 2, 0, 0);
    applyStimulus();
    checkOutput("len0_busyA", 32'(bus_a.busy), 32'd0);

    $display("[TB] pause then stop in gap");
    setupPlay(2, 4, 1, 0);
    applyStimulus();
    for (int c = 1; c <= 12; c++) begin
      s_pause = (c >= 2 && c <= 6) ? 1 : 0;
      s_stop  = (c == 11) ? 1 : 0;
      applyStimulus();
      if (c + 1 == 9)  checkOutput("pause_seg9A", 32'(bus_a.seg_out), 32'h3F);
      if (c + 1 == 10) checkOutput("pause_seg10A", 32'(bus_a.seg_out), 32'h00);
      if (c + 1 == 12) checkOutput("stop_busyA", 32'(bus_a.busy), 32'd0);
      if (c + 1 == 12) checkOutput("stop_doneA", 32'(bus_a.done), 32'd0);
      if (c + 1 == 12) checkOutput("stop_segB", 32'(bus_b.seg_out), 32'hFF);
    end

    $display("[TB] length clamp and restart");
    for (int i = 0; i < ML; i++) writeChar(i, int'($urandom_range(0, 255)));
    setupPlay(ML + 1, 1, 0, 0);
    applyStimulus();
    for (int c = 2; c <= 18; c++) begin
      applyStimulus();
      if (c == 16) checkOutput("clamp_idx16A", 32'(bus_a.char_idx), 32'd15);
      if (c == 17) checkOutput("clamp_done17A", 32'(bus_a.done), 32'd1);
    end
    setupPlay(8, 3, 0, 0);
    applyStimulus();
    for (int c = 1; c <= 20; c++) begin
      s_start = (c == 17) ? 1 : 0;
      applyStimulus();
      if (c + 1 == 17) checkOutput("rst_idx17A", 32'(bus_a.char_idx), 32'd5);
      if (c + 1 == 18) checkOutput("rst_idx18A", 32'(bus_a.char_idx), 32'd0);
      if (c + 1 == 21) checkOutput("rst_idx21A", 32'(bus_a.char_idx), 32'd1);
    end

    $display("[TB] randomized playback");
    for (int n = 0; n < 3000; n++) begin
      s_reset   = ($urandom_range(0, 999) == 0) ? 1 : 0;
      s_wr_en   = ($urandom_range(0, 4) == 0) ? 1 : 0;
      s_wr_addr = int'($urandom_range(0, ML - 1));
      s_wr_data = int'($urandom_range(0, 255));
      s_start   = ($urandom_range(0, 40) == 0) ? 1 : 0;
      s_len     = int'($urandom_range(1, ML + 1));
      s_dwell   = int'($urandom_range(0, 3));
      s_gap     = int'($urandom_range(0, 1));
      s_loop    = int'($urandom_range(0, 1));
      s_stop    = ($urandom_range(0, 150) == 0) ? 1 : 0;
      s_pause   = ($urandom_range(0, 9) == 0) ? 1 : 0;
      applyStimulus();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
